pwm_address_generator: RTL and testbench
========================================

// Module: pwm_address_generator
// PURPOSE
//  Parametrised successor of the free-running PWM address counter. Generates the
//  table/compare address for the PWM modulator with selectable waveform mode
//  (up-sawtooth, down-sawtooth, triangle, hold), programmable step and a built-in
//  clock-enable prescaler. Sits between the system clock and the LUT/comparator.
// PARAMETERS
//  COUNT_WIDTH     7    width of Address; must satisfy MAX_VALUE < 2**COUNT_WIDTH
//  MAX_VALUE       100  highest address produced; sequence range is 0..MAX_VALUE
//  STEP_WIDTH      4    width of Step input
//  PRESCALE_WIDTH  8    width of Prescale input / internal prescale counter
// PORTS
//  Clk       in   1               system clock, rising edge
//  Rst_n     in   1               asynchronous, active-low reset
//  En        in   1               run enable; 0 freezes prescaler and address
//  Clr       in   1               synchronous clear, priority over all but Rst_n
//  Mode      in   2               0 up-saw, 1 down-saw, 2 triangle, 3 hold
//  Step      in   STEP_WIDTH      address increment per tick (0 = no movement)
//  Prescale  in   PRESCALE_WIDTH  tick every Prescale+1 enabled cycles
//  Address   out  COUNT_WIDTH     registered current address
//  Dir       out  1               registered direction, 0 = up, 1 = down
//  Wrap      out  1               registered 1-cycle pulse at end of period
//  Tick      out  1               combinational: En && (pc == Prescale)
// BEHAVIOUR
//  - Rst_n low (async) or Clr high (sync): Address=0, Dir=0, Wrap=0, pc=0.
//  - Prescaler pc: when En=1, pc==Prescale -> pc<=0 and Tick=1, else pc<=pc+1.
//    En=0: pc holds, Tick=0. Prescale changed mid-count: if pc>Prescale, pc<=0
//    on the next enabled edge (no tick).
//  - Wrap defaults to 0 every cycle; set only on a tick edge as specified below.
//  - Effective step s = min(Step, MAX_VALUE); arithmetic done COUNT_WIDTH+2 wide.
//  - On Tick edge (latency 1: Address/Dir/Wrap update on the same edge):
//    Mode 0: n=Address+s; n>MAX_VALUE -> Address<=n-(MAX_VALUE+1), Wrap<=1;
//            else Address<=n. Dir<=0.
//    Mode 1: s>Address -> Address<=Address+MAX_VALUE+1-s, Wrap<=1;
//            else Address<=Address-s. Dir<=1.
//    Mode 2 (two states UP/DOWN held in Dir):
//            UP:   Address+s>=MAX_VALUE -> Address<=MAX_VALUE, Dir<=1; else +s.
//            DOWN: Address<=s -> Address<=0, Dir<=0, Wrap<=1; else -s.
//            Peak and trough each held for exactly one tick (clamped, not
//            reflected).
//    Mode 3: Address, Dir hold; Wrap 0; prescaler keeps running.
//  - s=0 in any mode: Address and Dir hold, no Wrap.
//  - Mode change takes effect on the next tick; entering mode 2 keeps current
//    Dir (down-saw -> triangle continues downward).
//  - Clr and Tick same cycle: Clr wins, no Wrap.
//  - Address never exceeds MAX_VALUE for any input sequence.
// TESTING (COUNT_WIDTH=7, MAX_VALUE=100)
//  1 Rst_n pulse, Mode=0, Step=1, Prescale=0, En=1 -> Address 0,1..100,0; Wrap
//    high only with the 100->0 update; period 101 clocks; Dir=0 throughout.
//  2 Mode=0, Step=3, Address=99 -> next tick Address=1, Wrap=1; then 4, Wrap=0.
//  3 Mode=1, Step=1, Address=0 -> Address=100, Wrap=1, Dir=1; then 99.
//  4 Mode=2, Step=10 from 0 -> 10..100 (Dir=1 at 100), 90..0 with Wrap and
//    Dir=0 at 0; period 20 ticks; Step=15 -> 90,100 clamp and 10,0 clamp.
//  5 Prescale=3 -> Address advances every 4 clocks, Tick 1-in-4; En=0 for 5
//    clocks mid-count -> pc, Address frozen, resume exactly where left.
//  6 Rst_n low between edges at Address=57 -> Address=0, Dir=0 immediately;
//    Clr with Tick at Address=100 mode 0 -> Address=0, Wrap=0; Mode=3 -> hold.

Source files
------------

// File: rtl/pwm_address_generator.sv
// PWM table/compare address generator: up-saw, down-saw, triangle and hold modes
// with programmable step and a clock-enable prescaler.
module pwm_address_generator #(
    parameter int COUNT_WIDTH    = 7,
    parameter int MAX_VALUE      = 100,
    parameter int STEP_WIDTH     = 4,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      clr,
    input  logic [1:0]                mode,
    input  logic [STEP_WIDTH-1:0]     step,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic [COUNT_WIDTH-1:0]    address,
    output logic                      dir,
    output logic                      wrap,
    output logic                      tick
);

    localparam int AW = COUNT_WIDTH + 2;
    localparam logic [AW-1:0] MAX_EXT    = AW'(MAX_VALUE);
    localparam logic [AW-1:0] PERIOD_EXT = AW'(MAX_VALUE + 1);

    localparam logic [1:0] MODE_UP   = 2'd0;
    localparam logic [1:0] MODE_DOWN = 2'd1;
    localparam logic [1:0] MODE_TRI  = 2'd2;
    localparam logic [1:0] MODE_HOLD = 2'd3;

    // Step clamped to the range so a single tick can wrap at most once.
    function automatic logic [AW-1:0] eff_step(input logic [STEP_WIDTH-1:0] st);
        logic [AW-1:0] r;
        if (32'(st) > 32'(MAX_VALUE)) begin
            r = MAX_EXT;
        end else begin
            r = AW'(st);
        end
        return r;
    endfunction

    logic [PRESCALE_WIDTH-1:0] pc_r;
    logic [PRESCALE_WIDTH-1:0] pc_next_s;
    logic [COUNT_WIDTH-1:0]    address_r;
    logic                      dir_r;
    logic                      wrap_r;
    logic [AW-1:0]             addr_next_s;
    logic                      dir_next_s;
    logic                      wrap_next_s;
    logic [AW-1:0]             s_s;
    logic [AW-1:0]             a_s;
    logic [AW-1:0]             sum_s;

    assign s_s   = eff_step(step);
    assign a_s   = AW'(address_r);
    assign sum_s = a_s + s_s;

    // Output decode: tick is the only combinational output.
    always_comb begin
        tick = en && (pc_r == prescale);
    end

    // Prescaler next count; a shrunken prescale above pc restarts without a tick.
    always_comb begin
        pc_next_s = pc_r;
        if (en) begin
            if (pc_r >= prescale) begin
                pc_next_s = {PRESCALE_WIDTH{1'b0}};
            end else begin
                pc_next_s = pc_r + PRESCALE_WIDTH'(1);
            end
        end else begin
            pc_next_s = pc_r;
        end
    end

    // Next address/direction/wrap; triangle phase lives in dir_r.
    always_comb begin
        addr_next_s = a_s;
        dir_next_s  = dir_r;
        wrap_next_s = 1'b0;
        if (tick && (s_s != {AW{1'b0}})) begin
            case (mode)
                MODE_UP: begin
                    dir_next_s = 1'b0;
                    if (sum_s > MAX_EXT) begin
                        addr_next_s = sum_s - PERIOD_EXT;
                        wrap_next_s = 1'b1;
                    end else begin
                        addr_next_s = sum_s;
                    end
                end
                MODE_DOWN: begin
                    dir_next_s = 1'b1;
                    if (s_s > a_s) begin
                        addr_next_s = a_s + PERIOD_EXT - s_s;
                        wrap_next_s = 1'b1;
                    end else begin
                        addr_next_s = a_s - s_s;
                    end
                end
                MODE_TRI: begin
                    if (!dir_r) begin
                        if (sum_s >= MAX_EXT) begin
                            addr_next_s = MAX_EXT;
                            dir_next_s  = 1'b1;
                        end else begin
                            addr_next_s = sum_s;
                        end
                    end else begin
                        if (a_s <= s_s) begin
                            addr_next_s = {AW{1'b0}};
                            dir_next_s  = 1'b0;
                            wrap_next_s = 1'b1;
                        end else begin
                            addr_next_s = a_s - s_s;
                        end
                    end
                end
                MODE_HOLD: begin
                    addr_next_s = a_s;
                end
                default: begin
                    addr_next_s = a_s;
                end
            endcase
        end else begin
            addr_next_s = a_s;
        end
    end

    // State register; clr behaves like reset but synchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r      <= {PRESCALE_WIDTH{1'b0}};
            address_r <= {COUNT_WIDTH{1'b0}};
            dir_r     <= 1'b0;
            wrap_r    <= 1'b0;
        end else if (clr) begin
            pc_r      <= {PRESCALE_WIDTH{1'b0}};
            address_r <= {COUNT_WIDTH{1'b0}};
            dir_r     <= 1'b0;
            wrap_r    <= 1'b0;
        end else begin
            pc_r      <= pc_next_s;
            address_r <= COUNT_WIDTH'(addr_next_s);
            dir_r     <= dir_next_s;
            wrap_r    <= wrap_next_s;
        end
    end

    assign address = address_r;
    assign dir     = dir_r;
    assign wrap    = wrap_r;

endmodule

// File: tb/tb_pwm_address_generator.sv
// Directed bench for pwm_address_generator (COUNT_WIDTH=7, MAX_VALUE=100).
module tb_pwm_address_generator;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic [1:0] mode;
    logic [3:0] step;
    logic [7:0] prescale;
    logic [6:0] address;
    logic       dir;
    logic       wrap;
    logic       tick;

    int total = 0;
    int bad   = 0;

    pwm_address_generator #(
        .COUNT_WIDTH(7), .MAX_VALUE(100), .STEP_WIDTH(4), .PRESCALE_WIDTH(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode), .step(step),
        .prescale(prescale), .address(address), .dir(dir), .wrap(wrap), .tick(tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; mode = 2'd0; step = 4'd1; prescale = 8'd0;
        cyc(); cyc();
        total++;
        if ({address, dir, wrap, tick} !== {7'd0, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset got a=%0d d=%0b w=%0b t=%0b exp 0 0 0 0", address, dir, wrap, tick);
        end
        en = 1'b1;
        cyc();
        total++;
        if ({address, tick} !== {7'd0, 1'b1}) begin
            bad++;
            $display("FAIL reset_hold got a=%0d t=%0b exp a=0 t=1", address, tick);
        end
    endtask

    task automatic test_up_saw();
        logic [6:0] ea;
        logic       ew;
        rst_n = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            cyc();
            ea = 7'(i);
            total++;
            if ({address, dir, wrap} !== {ea, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL up_saw i=%0d got a=%0d d=%0b w=%0b exp a=%0d d=0 w=0", i, address, dir, wrap, ea);
            end
        end
        for (int i = 1; i <= 102; i++) begin
            cyc();
            ea = 7'((i - 1) % 101);
            ew = (i == 1) || (i == 102);
            total++;
            if ({address, dir, wrap} !== {ea, 1'b0, ew}) begin
                bad++;
                $display("FAIL up_period i=%0d got a=%0d d=%0b w=%0b exp a=%0d d=0 w=%0b", i, address, dir, wrap, ea, ew);
            end
        end
    endtask

    task automatic test_step3();
        clr = 1'b1;
        cyc();
        total++;
        if ({address, dir, wrap} !== {7'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL clr got a=%0d d=%0b w=%0b exp 0 0 0", address, dir, wrap);
        end
        clr = 1'b0; step = 4'd3;
        for (int i = 0; i < 33; i++) cyc();
        total++;
        if (address !== 7'd99) begin
            bad++;
            $display("FAIL step3_reach got a=%0d exp 99", address);
        end
        cyc();
        total++;
        if ({address, wrap} !== {7'd1, 1'b1}) begin
            bad++;
            $display("FAIL step3_wrap got a=%0d w=%0b exp a=1 w=1", address, wrap);
        end
        cyc();
        total++;
        if ({address, wrap} !== {7'd4, 1'b0}) begin
            bad++;
            $display("FAIL step3_next got a=%0d w=%0b exp a=4 w=0", address, wrap);
        end
    endtask

    task automatic test_down_saw();
        clr = 1'b1; cyc(); clr = 1'b0;
        mode = 2'd1; step = 4'd1;
        cyc();
        total++;
        if ({address, dir, wrap} !== {7'd100, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL down_wrap got a=%0d d=%0b w=%0b exp 100 1 1", address, dir, wrap);
        end
        cyc();
        total++;
        if ({address, dir, wrap} !== {7'd99, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL down_next got a=%0d d=%0b w=%0b exp 99 1 0", address, dir, wrap);
        end
        mode = 2'd2; step = 4'd10;
        cyc();
        total++;
        if ({address, dir, wrap} !== {7'd89, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL down_to_tri got a=%0d d=%0b w=%0b exp 89 1 0", address, dir, wrap);
        end
    endtask

    task automatic test_triangle();
        logic [6:0] ea;
        logic       ed;
        logic       ew;
        clr = 1'b1; cyc(); clr = 1'b0;
        mode = 2'd2; step = 4'd10;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            ea = (k <= 10) ? 7'(10 * k) : 7'(100 - 10 * (k - 10));
            ed = (k >= 10) && (k < 20);
            ew = (k == 20);
            total++;
            if ({address, dir, wrap} !== {ea, ed, ew}) begin
                bad++;
                $display("FAIL tri10 k=%0d got a=%0d d=%0b w=%0b exp a=%0d d=%0b w=%0b", k, address, dir, wrap, ea, ed, ew);
            end
        end
        step = 4'd15;
        for (int k = 1; k <= 14; k++) begin
            cyc();
            if (k <= 6) ea = 7'(15 * k);
            else if (k == 7) ea = 7'd100;
            else if (k <= 13) ea = 7'(100 - 15 * (k - 7));
            else ea = 7'd0;
            ed = (k >= 7) && (k < 14);
            ew = (k == 14);
            total++;
            if ({address, dir, wrap} !== {ea, ed, ew}) begin
                bad++;
                $display("FAIL tri15 k=%0d got a=%0d d=%0b w=%0b exp a=%0d d=%0b w=%0b", k, address, dir, wrap, ea, ed, ew);
            end
        end
        step = 4'd0;
        cyc(); cyc();
        total++;
        if ({address, dir, wrap} !== {7'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL step0_hold got a=%0d d=%0b w=%0b exp 0 0 0", address, dir, wrap);
        end
    endtask

    task automatic test_prescale();
        logic [6:0] ea;
        logic       et;
        clr = 1'b1; mode = 2'd0; step = 4'd1; prescale = 8'd3;
        cyc();
        clr = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            cyc();
            ea = 7'(k / 4);
            et = (k % 4 == 3);
            total++;
            if ({address, tick} !== {ea, et}) begin
                bad++;
                $display("FAIL presc k=%0d got a=%0d t=%0b exp a=%0d t=%0b", k, address, tick, ea, et);
            end
        end
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            total++;
            if ({address, tick} !== {7'd2, 1'b0}) begin
                bad++;
                $display("FAIL presc_freeze k=%0d got a=%0d t=%0b exp a=2 t=0", k, address, tick);
            end
        end
        en = 1'b1;
        for (int k = 10; k <= 13; k++) begin
            cyc();
            ea = 7'(k / 4);
            et = (k % 4 == 3);
            total++;
            if ({address, tick} !== {ea, et}) begin
                bad++;
                $display("FAIL presc_resume k=%0d got a=%0d t=%0b exp a=%0d t=%0b", k, address, tick, ea, et);
            end
        end
        prescale = 8'd5;
        cyc(); cyc();
        prescale = 8'd1;
        #1;
        total++;
        if ({address, tick} !== {7'd3, 1'b0}) begin
            bad++;
            $display("FAIL presc_shrink got a=%0d t=%0b exp a=3 t=0", address, tick);
        end
        cyc();
        total++;
        if ({address, tick} !== {7'd3, 1'b0}) begin
            bad++;
            $display("FAIL presc_restart got a=%0d t=%0b exp a=3 t=0", address, tick);
        end
        cyc();
        total++;
        if ({address, tick} !== {7'd3, 1'b1}) begin
            bad++;
            $display("FAIL presc_tick got a=%0d t=%0b exp a=3 t=1", address, tick);
        end
        cyc();
        total++;
        if (address !== 7'd4) begin
            bad++;
            $display("FAIL presc_adv got a=%0d exp 4", address);
        end
    endtask

    task automatic test_reset_clr_hold();
        clr = 1'b1; mode = 2'd1; step = 4'd1; prescale = 8'd0;
        cyc();
        clr = 1'b0;
        for (int k = 0; k < 44; k++) cyc();
        total++;
        if ({address, dir} !== {7'd57, 1'b1}) begin
            bad++;
            $display("FAIL reach57 got a=%0d d=%0b exp a=57 d=1", address, dir);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({address, dir, wrap} !== {7'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL async_rst got a=%0d d=%0b w=%0b exp 0 0 0", address, dir, wrap);
        end
        #1 rst_n = 1'b1;
        mode = 2'd0;
        for (int k = 0; k < 100; k++) cyc();
        total++;
        if (address !== 7'd100) begin
            bad++;
            $display("FAIL reach100 got a=%0d exp 100", address);
        end
        clr = 1'b1;
        #1;
        total++;
        if (tick !== 1'b1) begin
            bad++;
            $display("FAIL clr_tick_pre got t=%0b exp 1", tick);
        end
        cyc();
        clr = 1'b0;
        total++;
        if ({address, dir, wrap} !== {7'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL clr_beats_tick got a=%0d d=%0b w=%0b exp 0 0 0", address, dir, wrap);
        end
        for (int k = 0; k < 5; k++) cyc();
        mode = 2'd3;
        for (int k = 0; k < 3; k++) begin
            cyc();
            total++;
            if ({address, dir, wrap, tick} !== {7'd5, 1'b0, 1'b0, 1'b1}) begin
                bad++;
                $display("FAIL mode3_hold k=%0d got a=%0d d=%0b w=%0b t=%0b exp 5 0 0 1", k, address, dir, wrap, tick);
            end
        end
    endtask

    initial begin
        test_reset();
        test_up_saw();
        test_step3();
        test_down_saw();
        test_triangle();
        test_prescale();
        test_reset_clr_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
